uart_rx_controller: RTL and testbench
=====================================

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clk_in frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit.
REQ-004 clk_in  input  1  system clock, 100 MHz; the block has one clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rx  input  1  serial line from host, asynchronous, idle high.
REQ-007 rx_ready  input  1  consumer accepts the held byte.
REQ-008 rx_data  output  8  received byte, LSB first on the line.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 overrun  output  1  one-cycle pulse when a byte is dropped.
REQ-012 parity_err  output  1  one-cycle pulse on a parity mismatch; constant 0 when parity is not compiled in.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-014 Tick generator SHALL pulse once every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clk_in cycles (integer division; 651 at defaults), free-running from reset.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- PARITY is reachable only with the parity macro.
REQ-016 IDLE->START SHALL occur on the first tick where the synchronized rx=0; the tick counter then clears.
REQ-017 Each bit SHALL be decided by 2-of-3 majority of samples at ticks 7, 8 and 9 of the bit.
- Tick numbering is 0..OVERSAMPLE-1.
REQ-018 START SHALL return to IDLE with no output when the majority is 1 (glitch reject); otherwise it goes to DATA.
REQ-019 DATA SHALL shift 8 bits LSB-first into a shift register, then go to PARITY (if enabled) or STOP.
REQ-020 Decision in STOP:
- majority 0 -> frame_err pulse, byte discarded, return to IDLE after the line is seen high;
- majority 1 -> byte is complete.
REQ-021 On completion with rx_valid=0, rx_data SHALL load and rx_valid SHALL rise on the next clk_in edge.
- The FSM returns to IDLE at tick 9 of the stop bit, ready for the next start edge.
REQ-022 On completion with rx_valid=1 and rx_ready=0:
- pulse overrun;
- rx_data keeps the old byte;
- the new byte is dropped.
REQ-023 rx_valid SHALL clear on the cycle after rx_valid&&rx_ready.
- If a completion coincides with acceptance, the new byte loads and rx_valid stays 1, with no overrun.
REQ-024 rx_data SHALL be stable while rx_valid=1.
REQ-025 Latency from the stop-bit midpoint sample (tick 8) to rx_valid SHALL be at most 3 clk_in cycles.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold:
- FSM=IDLE;
- counters=0;
- rx_data=8'h00;
- rx_valid, frame_err, overrun and parity_err=0;
- synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL resume only on a new start edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined:
- frame is 8E1;
- PARITY state samples one even-parity bit;
- on mismatch, parity_err pulses and the byte is discarded;
- the frame is still checked for stop.
REQ-029 Macro absent: frame is 8N1, PARITY state and its logic are absent, parity_err is tied 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold:
- the FSM state enum;
- DATA_BITS=8;
- the sample tick constants 7/8/9;
- the divisor function.
The transmitter side shares this package.
REQ-031 Tick generation SHALL be sub-module uart_tick_gen.
- Ports: clk_in, rst_n, tick.
- Parameters: CLK_FREQ, BAUD, OVERSAMPLE.

Verification
REQ-032 Bench SHALL cover these directed scenarios at defaults:
- V1: 8N1 frame 0xA5 at 9600 baud, rx_ready=1 -> rx_data=8'hA5, rx_valid for 1 cycle, no error pulses.
- V2: rx low pulse of 4 ticks (~2600 cycles), then high -> FSM back to IDLE, rx_valid stays 0.
- V3: frame 0x3C with stop bit 0 -> frame_err single pulse, rx_valid 0; next valid frame 0x11 -> rx_data=8'h11.
- V4: frames 0x01 then 0x02 with rx_ready=0 -> rx_data=8'h01 held, overrun pulses once at the end of the second frame.
- V5: rst_n low mid-DATA of 0xFF, release, send 0x5A -> rx_data=8'h5A only, no errors.
- V6 (UART_RX_PARITY_EN): 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter.
// Holds the FSM state encoding, the frame width, the per-bit sample points
// and the baud divisor calculation.
package uart_pkg;

  // Data bits per frame
  localparam int DATA_BITS = 8;

  // Oversample ticks (0..OVERSAMPLE-1) at which a bit is sampled for voting
  localparam int SAMPLE_EARLY = 7;
  localparam int SAMPLE_MID   = 8;
  localparam int SAMPLE_LATE  = 9;

  // Receiver frame state; PARITY is only entered when parity is compiled in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Clock cycles per oversample tick; never less than one
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  // 2-of-3 majority vote
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator: one-cycle pulse on tick every
// calc_div(CLK_FREQ, BAUD, OVERSAMPLE) clk_in cycles.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Count 0..DIV-1 and fire tick as the count wraps
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      tick    <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver with oversampled 2-of-3 majority bit decisions and a
// one-byte valid/ready output holding register.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity bit
// checked, parity_err reported); otherwise frames are 8N1 and parity_err is 0.
// OVERSAMPLE must be greater than 9 so the sample ticks 7/8/9 exist.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_EARLY = TW'(SAMPLE_EARLY);
  localparam logic [TW-1:0] T_MID   = TW'(SAMPLE_MID);
  localparam logic [TW-1:0] T_LATE  = TW'(SAMPLE_LATE);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

  logic                 tick;
  logic                 rx_meta_reg, rx_sync_reg;
  uart_state_t          state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 s7_reg, s7_next;
  logic                 s8_reg, s8_next;
  logic                 stop_seen_reg, stop_seen_next;
  logic                 stop_bad_reg, stop_bad_next;
  logic                 at_last, at_late, bit_maj, byte_ok;
  logic                 stop_early, stop_decide, stop_bit;
  logic                 byte_done, frame_fault;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_reg, par_bad_next;
  logic                 parity_fault;
`endif

  uart_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick_gen (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign at_last = (tick_cnt_reg == T_LAST);
  assign at_late = (tick_cnt_reg == T_LATE);
  // Vote of the three stored/current samples, valid on tick 9
  assign bit_maj = majority3(s7_reg, s8_reg, rx_sync_reg);

`ifdef UART_RX_PARITY_EN
  assign byte_ok = ~par_bad_reg;
`else
  assign byte_ok = 1'b1;
`endif

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Frame FSM and datapath state registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      s7_reg        <= 1'b1;
      s8_reg        <= 1'b1;
      stop_seen_reg <= 1'b0;
      stop_bad_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      s7_reg        <= s7_next;
      s8_reg        <= s8_next;
      stop_seen_reg <= stop_seen_next;
      stop_bad_reg  <= stop_bad_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg   <= par_bad_next;
`endif
    end
  end

  // Next-state logic: bit timing, sampling, voting and frame decisions
  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    s7_next        = s7_reg;
    s8_next        = s8_reg;
    stop_seen_next = stop_seen_reg;
    stop_bad_next  = stop_bad_reg;
`ifdef UART_RX_PARITY_EN
    par_bad_next   = par_bad_reg;
    parity_fault   = 1'b0;
`endif
    byte_done      = 1'b0;
    frame_fault    = 1'b0;
    stop_early     = 1'b0;
    stop_decide    = 1'b0;
    stop_bit       = 1'b1;

    // Inside a frame: advance the bit-relative tick count and capture samples
    if (state_reg != IDLE && tick) begin
      tick_cnt_next = at_last ? '0 : tick_cnt_reg + 1'b1;
      if (tick_cnt_reg == T_EARLY) s7_next = rx_sync_reg;
      if (tick_cnt_reg == T_MID)   s8_next = rx_sync_reg;
    end

    case (state_reg)
      IDLE: begin
        tick_cnt_next  = '0;
        bit_cnt_next   = '0;
        stop_seen_next = 1'b0;
        stop_bad_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next   = 1'b0;
`endif
        // The tick that sees the line low is tick 0 of the start bit
        if (tick && !rx_sync_reg) state_next = START;
      end

      START: begin
        if (tick && at_late && bit_maj) begin
          state_next = IDLE;              // glitch, not a real start bit
        end else if (tick && at_last) begin
          state_next = DATA;
        end
      end

      DATA: begin
        if (tick && at_late) shift_next = {bit_maj, shift_reg[DATA_BITS-1:1]};
        if (tick && at_last) begin
          if (bit_cnt_reg == B_LAST) begin
            bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: data bits plus parity bit must XOR to zero
        if (tick && at_late && ((^shift_reg) ^ bit_maj)) begin
          par_bad_next = 1'b1;
          parity_fault = 1'b1;
        end
        if (tick && at_last) state_next = STOP;
      end
`endif

      STOP: begin
        if (stop_bad_reg) begin
          // Bad stop bit: hold off until the line returns high
          if (rx_sync_reg) state_next = IDLE;
        end else begin
          // Agreeing samples at 7 and 8 already fix the vote, so the byte is
          // released at the midpoint; a split vote waits for tick 9.
          stop_early  = tick && (tick_cnt_reg == T_MID) && (rx_sync_reg == s7_reg);
          stop_decide = !stop_seen_reg && (stop_early || (tick && at_late));
          stop_bit    = stop_early ? rx_sync_reg : bit_maj;
          if (stop_decide) begin
            stop_seen_next = 1'b1;
            if (stop_bit) begin
              byte_done     = byte_ok;
            end else begin
              frame_fault   = 1'b1;
              stop_bad_next = 1'b1;
            end
          end
          if (tick && at_late && ((stop_seen_reg && !stop_decide) || (stop_decide && stop_bit))) begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Output holding register with valid/ready handshake and error pulses
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_fault;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Registered parity mismatch pulse
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= parity_fault;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed testbench for uart_rx_controller. The DUT runs with a scaled
// clock/baud (4 clocks per tick, 64 clocks per bit) so frames stay short.
// Define UART_RX_PARITY_EN for both DUT and bench to exercise 8E1 frames.
module tb_uart_rx_controller;

  localparam int BIT_CYC = 64;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int errors = 0;
  int checks = 0;

  // Monitor counters (written only by the monitor)
  int         valid_rises = 0;
  int         valid_cycles = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         stab_viol = 0;
  logic       valid_d = 1'b0;
  logic [7:0] data_d = 8'h00;
  logic [7:0] last_data = 8'h00;

  uart_rx_controller #(
    .CLK_FREQ  (6_400_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs on the falling edge
  always @(negedge clk) begin
    if (rx_valid && !valid_d) begin
      valid_rises = valid_rises + 1;
      last_data   = rx_data;
      $display("  byte received: %02h", rx_data);
    end
    if (rx_valid) valid_cycles = valid_cycles + 1;
    if (rx_valid && valid_d && rx_data !== data_d) stab_viol = stab_viol + 1;
    if (frame_err)  fe_cnt = fe_cnt + 1;
    if (overrun)    ov_cnt = ov_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
    valid_d = rx_valid;
    data_d  = rx_data;
  end

  task automatic send_raw(input logic [10:0] bits, input int nbits);
    rx = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (BIT_CYC) @(posedge clk);
    end
    rx = 1'b1;
  endtask

  // One frame with correct parity (when enabled) and the given stop bit
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, ^d, d};
`else
    bits = {1'b0, stop_bit, d};
`endif
    send_raw(bits, NBITS);
    $display("  frame sent: data=%02h stop=%0d", d, stop_bit);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    @(posedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int r0, c0, f0, o0, p0;
    rx_ready = 1'b1;
    r0 = valid_rises; c0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    send_byte(8'hA5, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_rises - r0 !== 1)  begin errors++; $display("FAIL v1_rises: got %0d expected 1", valid_rises - r0); end
    checks++; if (last_data !== 8'hA5)     begin errors++; $display("FAIL v1_data: got %h expected a5", last_data); end
    checks++; if (valid_cycles - c0 !== 1) begin errors++; $display("FAIL v1_valid_cycles: got %0d expected 1", valid_cycles - c0); end
    checks++; if (fe_cnt - f0 !== 0)       begin errors++; $display("FAIL v1_frame_err: got %0d expected 0", fe_cnt - f0); end
    checks++; if (ov_cnt - o0 !== 0)       begin errors++; $display("FAIL v1_overrun: got %0d expected 0", ov_cnt - o0); end
    checks++; if (pe_cnt - p0 !== 0)       begin errors++; $display("FAIL v1_parity_err: got %0d expected 0", pe_cnt - p0); end
    $display("test_basic done");
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = valid_rises; f0 = fe_cnt;
    rx = 1'b0;
    repeat (16) @(posedge clk);   // 4 ticks low
    rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_rises - r0 !== 0) begin errors++; $display("FAIL v2_rises: got %0d expected 0", valid_rises - r0); end
    checks++; if (fe_cnt - f0 !== 0)      begin errors++; $display("FAIL v2_frame_err: got %0d expected 0", fe_cnt - f0); end
    checks++; if (rx_valid !== 1'b0)      begin errors++; $display("FAIL v2_valid: got %b expected 0", rx_valid); end
    $display("test_glitch done");
  endtask

  task automatic test_frame_error;
    int r0, f0;
    r0 = valid_rises; f0 = fe_cnt;
    send_byte(8'h3C, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (fe_cnt - f0 !== 1)      begin errors++; $display("FAIL v3_frame_err: got %0d expected 1", fe_cnt - f0); end
    checks++; if (valid_rises - r0 !== 0) begin errors++; $display("FAIL v3_no_valid: got %0d expected 0", valid_rises - r0); end
    r0 = valid_rises;
    send_byte(8'h11, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_rises - r0 !== 1) begin errors++; $display("FAIL v3_next_rises: got %0d expected 1", valid_rises - r0); end
    checks++; if (last_data !== 8'h11)    begin errors++; $display("FAIL v3_next_data: got %h expected 11", last_data); end
    $display("test_frame_error done");
  endtask

  task automatic test_overrun;
    int o0;
    rx_ready = 1'b0;
    o0 = ov_cnt;
    send_byte(8'h01, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL v4_first_valid: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL v4_first_data: got %h expected 01", rx_data); end
    checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL v4_first_overrun: got %0d expected 0", ov_cnt - o0); end
    send_byte(8'h02, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL v4_overrun: got %0d expected 1", ov_cnt - o0); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL v4_held_data: got %h expected 01", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL v4_held_valid: got %b expected 1", rx_valid); end
    @(posedge clk);
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL v4_accept_clear: got %b expected 0", rx_valid); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_midframe;
    int r0, f0, o0;
    rx = 1'b0;                            // start of 0xFF frame
    repeat (BIT_CYC) @(posedge clk);
    rx = 1'b1;                            // data bits of 0xFF
    repeat (2 * BIT_CYC + 20) @(posedge clk);
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL v5_reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL v5_reset_data: got %h expected 00", rx_data); end
    @(posedge clk);
    rst_n = 1'b1;
    repeat (700) @(posedge clk);
    r0 = valid_rises; f0 = fe_cnt; o0 = ov_cnt;
    send_byte(8'h5A, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_rises - r0 !== 1) begin errors++; $display("FAIL v5_rises: got %0d expected 1", valid_rises - r0); end
    checks++; if (last_data !== 8'h5A)    begin errors++; $display("FAIL v5_data: got %h expected 5a", last_data); end
    checks++; if (fe_cnt - f0 !== 0)      begin errors++; $display("FAIL v5_frame_err: got %0d expected 0", fe_cnt - f0); end
    checks++; if (ov_cnt - o0 !== 0)      begin errors++; $display("FAIL v5_overrun: got %0d expected 0", ov_cnt - o0); end
    $display("test_reset_midframe done");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int r0, p0;
    logic [10:0] bits;
    r0 = valid_rises; p0 = pe_cnt;
    bits = {1'b0, 1'b1, 1'b0, 8'h07};     // 0x07 with wrong parity bit 0
    send_raw(bits, NBITS);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (pe_cnt - p0 !== 1)      begin errors++; $display("FAIL v6_parity_err: got %0d expected 1", pe_cnt - p0); end
    checks++; if (valid_rises - r0 !== 0) begin errors++; $display("FAIL v6_no_valid: got %0d expected 0", valid_rises - r0); end
    r0 = valid_rises; p0 = pe_cnt;
    bits = {1'b0, 1'b1, 1'b1, 8'h07};     // 0x07 with correct parity bit 1
    send_raw(bits, NBITS);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_rises - r0 !== 1) begin errors++; $display("FAIL v6_rises: got %0d expected 1", valid_rises - r0); end
    checks++; if (last_data !== 8'h07)    begin errors++; $display("FAIL v6_data: got %h expected 07", last_data); end
    checks++; if (pe_cnt - p0 !== 0)      begin errors++; $display("FAIL v6_no_parity_err: got %0d expected 0", pe_cnt - p0); end
    $display("test_parity done");
  endtask
`endif

  task automatic test_stability;
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL data_stable: got %0d changes expected 0", stab_viol); end
    $display("test_stability done");
  endtask

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
